// File: rtl/piso_unloader.sv
// Parallel-in serial-out unloader: captures a word on start and presents it one bit
// per accepted ready/valid handshake, then pulses done for one cycle.
module piso_unloader #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             sout_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic [5:0]       bit_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign accept = (state == SHIFT) && sout_ready;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt = d;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Shift toward the output end with zero fill only on a handshake.
                if (accept) begin
                    shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only; start and d never reach them combinationally.
    assign sout_valid = (state == SHIFT);
    assign sout       = (state == SHIFT) & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign bit_cnt    = cnt;

endmodule

// File: doc/piso_unloader.md
PISO_UNLOADER -- requirements
Module: piso_unloader

Interface
REQ-001 Parameter: WIDTH, default 32, word width in bits; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 0; 0 = serialize LSB first, 1 = serialize MSB first.
REQ-003 The block SHALL have a single clock and a reset that is synchronous and active-high, named as the codebase does: clk and rst.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request to capture d and begin serializing.
REQ-007 Port: d  input  WIDTH  parallel word, sampled only on an accepted start.
REQ-008 Port: sout_ready  input  1  downstream accepts the current serial bit.
REQ-009 Port: sout  output  1  current serial bit.
REQ-010 Port: sout_valid  output  1  sout holds a valid bit.
REQ-011 Port: busy  output  1  high in SHIFT and DONE states.
REQ-012 Port: done  output  1  one-cycle pulse after the last bit is accepted.
REQ-013 Port: bit_cnt  output  6  index of the bit currently presented, 0..WIDTH-1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL load shreg<=d and bit_cnt<=0, and move the FSM to SHIFT; the first bit appears the cycle after start.
REQ-016 In SHIFT, sout_valid SHALL be 1 and sout SHALL be shreg[0] when MSB_FIRST=0, or shreg[WIDTH-1] when MSB_FIRST=1.
REQ-017 A bit is accepted on an edge where sout_valid=1 and sout_ready=1; only then SHALL shreg shift by one toward the output end (zero fill) and bit_cnt increment.
REQ-018 With sout_ready=0 in SHIFT, sout, bit_cnt and shreg SHALL hold their values with no timeout.
REQ-019 Acceptance of the bit at bit_cnt=WIDTH-1 SHALL move the FSM to DONE and clear bit_cnt to 0.
REQ-020 In DONE, done=1 and sout_valid=0 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-021 start SHALL be ignored in SHIFT and DONE; d is not re-sampled and no request is queued.
REQ-022 start asserted in the first IDLE cycle after DONE SHALL be accepted, so the minimum word period is WIDTH+2 cycles with sout_ready tied to 1.
REQ-023 In IDLE and DONE, sout SHALL be driven 0.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 All outputs SHALL be glitch-free functions of registered state; there is no combinational path from start or d to any output.

Reset
REQ-026 rst=1 at a rising edge SHALL force state=IDLE, shreg=0, bit_cnt=0, sout=0, sout_valid=0, busy=0 and done=0.
REQ-027 rst SHALL take priority over start and over a bit acceptance in the same cycle.
REQ-028 rst asserted mid-word SHALL abort the transfer, with no done pulse and no further valid bits.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-030 Basic transfer: WIDTH=32, MSB_FIRST=0, d=32'hA5A5_0F0F, start pulse, sout_ready=1 -> from the next cycle, 32 valid bits 1,1,1,1,0,0,0,0,... (LSB first) on consecutive cycles, then done=1 for exactly one cycle, and the word period is 34 cycles.
REQ-031 MSB-first transfer: MSB_FIRST=1, d=32'h8000_0001 -> first bit 1, then 30 zeros, then last bit 1, then done.
REQ-032 Backpressure: sout_ready toggles 1,0,1,0 -> each bit is held while sout_ready=0, the sequence is unchanged, done follows after 32 accepts, and bit_cnt is monotonic.
REQ-033 Ignored start: start=1 with d=32'hFFFF_FFFF at bit_cnt=5 of a transfer of d=0 -> all 32 output bits are 0 and busy stays high until DONE.
REQ-034 Reset mid-word: rst at bit_cnt=17 -> the next cycle has busy=0, sout_valid=0, bit_cnt=0, no done pulse, and a new start is accepted normally.
REQ-035 Back-to-back words: start held at 1 continuously -> a new word is captured in the IDLE cycle after each DONE, with a period of WIDTH+2.
